// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data memory controller.
// MEM_* values are the load/store access types carried on the 3-bit op field.
// The encodings 101, 110 and 111 are reserved and are rejected as errors.
package cpu_pkg;

  typedef enum logic [2:0] {
    MEM_W  = 3'b000,  // LW / SW
    MEM_H  = 3'b001,  // LH / SH
    MEM_HU = 3'b010,  // LHU (a store with this op is treated as a half store)
    MEM_B  = 3'b011,  // LB / SB
    MEM_BU = 3'b100   // LBU (a store with this op is treated as a byte store)
  } mem_op_e;

endpackage

// File: rtl/data_mem_ctrl_pkg.sv
// Local types for the data memory controller.
// state_e : CLEAR runs the zeroing sweep; IDLE accepts normal accesses.
// S_IDLE is encoded as 0, so a simulation that starts from all-zero state
// without a reset comes up ready for accesses.
package data_mem_ctrl_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Bus between the CPU and the data memory controller.
//   pc   : PC of the instruction issuing the access (used only for tracing)
//   addr : byte address
//   wd   : store data, right-aligned
//   we   : store request this cycle
//   op   : access type (cpu_pkg::MEM_*)
//   rd   : load data, already extended
//   busy : clear sweep in progress
//   err  : misaligned, out-of-range or reserved-op access this cycle
// The master modport is the CPU side; the slave modport is the memory side.
interface data_mem_ctrl_if;

  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        we;
  logic [2:0]  op;
  logic [31:0] rd;
  logic        busy;
  logic        err;

  modport master (output pc, addr, wd, we, op, input rd, busy, err);
  modport slave  (input pc, addr, wd, we, op, output rd, busy, err);

endinterface

// File: rtl/data_mem_ctrl_lane_unit.sv
// mem_lane_unit: combinational lane logic for the data memory controller.
// It selects the addressed half or byte from a word, extends it for loads,
// merges store data into the addressed lanes, and flags bad accesses.
// Ports:
//   op         : access type (cpu_pkg::MEM_*)
//   lane       : byte offset within the word
//   word_in    : current contents of the addressed word
//   wd         : right-aligned store data
//   load_data  : extended load result
//   store_word : word_in with the store data merged into the selected lanes
//   bad_access : misaligned for the op, or op reserved
module mem_lane_unit
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word_in,
  input  logic [31:0] wd,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        bad_access
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel   = lane[1] ? word_in[31:16] : word_in[15:0];
    byte_sel   = word_in[{lane, 3'b000} +: 8];
    load_data  = '0;
    store_word = word_in;
    bad_access = 1'b0;
    case (op)
      MEM_W: begin
        bad_access = (lane != 2'b00);
        load_data  = word_in;
        store_word = wd;
      end
      MEM_H: begin
        bad_access = lane[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
        store_word[{lane[1], 4'b0000} +: 16] = wd[15:0];
      end
      MEM_HU: begin
        bad_access = lane[0];
        load_data  = {16'h0000, half_sel};
        store_word[{lane[1], 4'b0000} +: 16] = wd[15:0];
      end
      MEM_B: begin
        load_data = {{24{byte_sel[7]}}, byte_sel};
        store_word[{lane, 3'b000} +: 8] = wd[7:0];
      end
      MEM_BU: begin
        load_data = {24'h000000, byte_sel};
        store_word[{lane, 3'b000} +: 8] = wd[7:0];
      end
      default: bad_access = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory with byte/half/word access.
// After reset it sweeps every word to zero (busy high) and then serves
// accesses. Reads are combinational; stores commit on the rising edge.
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (4..65536)
//   BASE_ADDR   : byte address mapped to word 0
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; restarts the clear sweep
//   bus   : data_mem_ctrl_if.slave (pc, addr, wd, we, op, rd, busy, err)
// Build option:
//   DATA_MEM_TRACE_EN : when defined, prints "@<pc>: *<addr> <= <word>"
//                       for every store that is performed.
module data_mem_ctrl
  import cpu_pkg::*;
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
  input  logic              clk,
  input  logic              reset,
  data_mem_ctrl_if.slave    bus
);

  localparam int unsigned   AW   = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  state_e        state, state_n;
  logic [AW-1:0] clr_cnt, clr_cnt_n;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [29:0]   idx;
  logic [1:0]    lane;
  logic          in_range;
  logic [AW-1:0] acc_idx;
  logic [31:0]   cur_word;
  logic [31:0]   load_data;
  logic [31:0]   store_word;
  logic          bad_access;
  logic          err_raw;
  logic          clear_fire;
  logic          store_fire;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;

  assign offset   = bus.addr - BASE_ADDR;
  assign idx      = offset[31:2];
  assign lane     = offset[1:0];
  assign in_range = ({2'b00, idx} < 32'(DEPTH_WORDS));
  // Out-of-range accesses are pointed at word 0 so the array is never
  // indexed past its end; their results are masked off by err anyway.
  assign acc_idx  = in_range ? idx[AW-1:0] : '0;
  assign cur_word = mem[acc_idx];

  mem_lane_unit u_lane (
    .op         (bus.op),
    .lane       (lane),
    .word_in    (cur_word),
    .wd         (bus.wd),
    .load_data  (load_data),
    .store_word (store_word),
    .bad_access (bad_access)
  );

  assign err_raw  = !in_range || bad_access;
  assign bus.busy = (state == S_CLEAR);
  assign bus.err  = !reset && err_raw;
  assign bus.rd   = (reset || err_raw || bus.busy) ? '0 : load_data;

  // The sweep owns the write port while busy; CPU stores are dropped then.
  assign clear_fire = !reset && (state == S_CLEAR);
  assign store_fire = !reset && bus.we && !err_raw && !bus.busy;
  assign wr_en      = clear_fire || store_fire;
  assign wr_idx     = clear_fire ? clr_cnt : acc_idx;
  assign wr_data    = clear_fire ? '0 : store_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    unique case (state)
      S_CLEAR: begin
        // The counter holds at LAST rather than wrapping.
        if (clr_cnt == LAST) state_n = S_IDLE;
        else                 clr_cnt_n = clr_cnt + AW'(1);
      end
      S_IDLE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

`ifdef DATA_MEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (store_fire)
      $display("@%08h: *%08h <= %08h", bus.pc,
               BASE_ADDR + {offset[31:2], 2'b00}, store_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_ctrl_if bus();

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(logic we, logic [2:0] op, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] rd, logic err);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wd = wd; v.exp_rd = rd; v.exp_err = err;
    vecs.push_back(v);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input string name,
                       input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    bus.we = we; bus.op = op; bus.addr = addr; bus.wd = wd;
    bus.pc = bus.pc + 32'd4;
    e.name = name; e.rd = exp_rd; e.err = exp_err;
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = sb.pop_front();
      check32({e.name, " rd"}, bus.rd, e.rd);
      check32({e.name, " err"}, 32'(bus.err), 32'(e.err));
    end
  endtask

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.we = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic scan_zero(input string name);
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      drive(1'b0, MEM_W, 32'(i * 4), 32'h0, name, 32'h0, 1'b0);
      #1 compare_pop();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b1;
    bus.we  = 1'b0;
    bus.op  = 3'b111;
    bus.addr = 32'h0000_0400;
    bus.wd  = 32'h0;
    bus.pc  = 32'h0000_1000;

    // Reset high: err and rd held low even for a reserved, out-of-range op.
    #1;
    sb.push_back('{"during reset", 32'h0, 1'b0});
    compare_pop();
    bus.op = MEM_W; bus.addr = 32'h0;
    @(negedge clk);
    reset = 1'b0;

    count_busy(n);
    check32("reset sweep busy cycles", 32'(n), 32'd16);
    scan_zero("zero after reset");

    add(1'b1, MEM_W,  32'h08, 32'h80FF_7F01, 32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h08, 32'h0,         32'h80FF_7F01, 1'b0);
    add(1'b0, MEM_B,  32'h08, 32'h0,         32'h0000_0001, 1'b0);
    add(1'b0, MEM_B,  32'h0B, 32'h0,         32'hFFFF_FF80, 1'b0);
    add(1'b0, MEM_BU, 32'h0B, 32'h0,         32'h0000_0080, 1'b0);
    add(1'b0, MEM_H,  32'h0A, 32'h0,         32'hFFFF_80FF, 1'b0);
    add(1'b0, MEM_HU, 32'h0A, 32'h0,         32'h0000_80FF, 1'b0);
    add(1'b0, MEM_H,  32'h08, 32'h0,         32'h0000_7F01, 1'b0);
    add(1'b0, MEM_B,  32'h09, 32'h0,         32'h0000_007F, 1'b0);
    add(1'b0, MEM_BU, 32'h0A, 32'h0,         32'h0000_00FF, 1'b0);
    add(1'b1, MEM_B,  32'h05, 32'h1234_56AB, 32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h04, 32'h0,         32'h0000_AB00, 1'b0);
    add(1'b1, MEM_W,  32'h06, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
    add(1'b0, MEM_W,  32'h04, 32'h0,         32'h0000_AB00, 1'b0);
    add(1'b1, MEM_H,  32'h03, 32'h0000_FFFF, 32'h0000_0000, 1'b1);
    add(1'b0, MEM_W,  32'h00, 32'h0,         32'h0000_0000, 1'b0);
    add(1'b1, MEM_W,  32'h40, 32'h1111_1111, 32'h0000_0000, 1'b1);
    add(1'b0, MEM_W,  32'h00, 32'h0,         32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h3C, 32'h0,         32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h40, 32'h0,         32'h0000_0000, 1'b1);
    add(1'b1, MEM_H,  32'h0E, 32'h0000_CAFE, 32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h0C, 32'h0,         32'hCAFE_0000, 1'b0);
    add(1'b1, MEM_B,  32'h0C, 32'h0000_0077, 32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h0C, 32'h0,         32'hCAFE_0077, 1'b0);
    add(1'b0, MEM_H,  32'h0E, 32'h0,         32'hFFFF_CAFE, 1'b0);
    add(1'b0, MEM_BU, 32'h0F, 32'h0,         32'h0000_00CA, 1'b0);
    add(1'b0, 3'b101, 32'h00, 32'h0,         32'h0000_0000, 1'b1);
    add(1'b1, 3'b111, 32'h0C, 32'h0,         32'h0000_0000, 1'b1);
    add(1'b0, MEM_W,  32'h0C, 32'h0,         32'hCAFE_0077, 1'b0);
    add(1'b0, MEM_HU, 32'h0D, 32'h0,         32'h0000_0000, 1'b1);
    add(1'b1, MEM_W,  32'h10, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
    add(1'b0, MEM_W,  32'h10, 32'h0,         32'hA5A5_A5A5, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wd,
            $sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_err);
      #1 compare_pop();
    end
    @(negedge clk);
    bus.we = 1'b0;

    // Store issued while the sweep is past word 0 must be dropped.
    pulse_reset();
    repeat (10) @(negedge clk);
    drive(1'b1, MEM_W, 32'h00, 32'hFFFF_FFFF, "store while busy", 32'h0, 1'b0);
    #1 compare_pop();
    @(negedge clk);
    bus.we = 1'b0;
    count_busy(n);
    check32("busy tail after store", 32'(n), 32'd5);
    scan_zero("zero after busy store");

    // Reset reasserted mid-sweep restarts it from word 0.
    @(negedge clk);
    drive(1'b1, MEM_W, 32'h28, 32'h0BAD_CAFE, "fill word 10", 32'h0, 1'b0);
    #1 compare_pop();
    @(negedge clk);
    drive(1'b1, MEM_W, 32'h3C, 32'hFEED_F00D, "fill word 15", 32'h0, 1'b0);
    #1 compare_pop();
    @(negedge clk);
    drive(1'b0, MEM_W, 32'h3C, 32'h0, "readback word 15", 32'hFEED_F00D, 1'b0);
    #1 compare_pop();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, MEM_W, 32'h3C, 32'h0, "reset masks rd", 32'h0, 1'b0);
    #1 compare_pop();
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    check32("busy at sweep cycle 7", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    drive(1'b0, 3'b111, 32'h0000_0400, 32'h0, "reset masks err", 32'h0, 1'b0);
    #1 compare_pop();
    @(negedge clk);
    reset = 1'b0;
    bus.op = MEM_W; bus.addr = 32'h0;
    count_busy(n);
    check32("restarted sweep busy cycles", 32'(n), 32'd16);
    scan_zero("zero after restart");

    check32("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
